// File: rtl/bcd_modn_counter_if.sv
// Control and display signals of the BCD modulo-N counter.
// The master side drives the controls; the slave side is the counter itself.
interface bcd_modn_counter_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] ld_units;
  logic [3:0] ld_tens;
  logic [3:0] led1;
  logic [3:0] led2;
  logic       tc;
  logic       err;

  modport master (
    output en, up, load, ld_units, ld_tens,
    input  led1, led2, tc, err
  );

  modport slave (
    input  en, up, load, ld_units, ld_tens,
    output led1, led2, tc, err
  );
endinterface

// File: rtl/bcd_modn_counter.sv
// Two-digit BCD up/down counter, modulo MODULUS, stepping once every
// PRESCALE enabled cycles. Supports a validated synchronous load; tc pulses
// on wrap and err pulses on a rejected load.
module bcd_modn_counter #(
  parameter int unsigned MODULUS  = 60,
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rs,
  bcd_modn_counter_if.slave bus
);

  localparam logic [3:0]  MAX_U = 4'((MODULUS - 1) % 10);
  localparam logic [3:0]  MAX_T = 4'((MODULUS - 1) / 10);
  localparam logic [15:0] PMAX  = 16'(PRESCALE - 1);
  localparam logic [7:0]  MOD8  = 8'(MODULUS);

  logic [3:0]  units_q, units_d;
  logic [3:0]  tens_q, tens_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        tc_q, tc_d;
  logic        err_q, err_d;

  logic [7:0]  ld_val;
  logic        ld_ok;
  logic        at_max;
  logic        at_zero;

  // Load is accepted only for two legal BCD digits forming a value below the modulus.
  always_comb begin
    ld_val = 8'(bus.ld_tens) * 8'd10 + 8'(bus.ld_units);
    ld_ok  = (bus.ld_units <= 4'd9) && (bus.ld_tens <= 4'd9) && (ld_val < MOD8);
  end

  assign at_max  = (units_q == MAX_U) && (tens_q == MAX_T);
  assign at_zero = (units_q == 4'd0) && (tens_q == 4'd0);

  // Next-state: load has priority over enable; a rejected load holds everything.
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (ld_ok) begin
        units_d = bus.ld_units;
        tens_d  = bus.ld_tens;
        pcnt_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (pcnt_q == PMAX) begin
        pcnt_d = '0;
        if (bus.up) begin
          if (at_max) begin
            units_d = '0;
            tens_d  = '0;
            tc_d    = 1'b1;
          end else if (units_q == 4'd9) begin
            units_d = '0;
            tens_d  = tens_q + 4'd1;
          end else begin
            units_d = units_q + 4'd1;
          end
        end else begin
          if (at_zero) begin
            units_d = MAX_U;
            tens_d  = MAX_T;
            tc_d    = 1'b1;
          end else if (units_q == 4'd0) begin
            units_d = 4'd9;
            tens_d  = tens_q - 4'd1;
          end else begin
            units_d = units_q - 4'd1;
          end
        end
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end
  end

  // State and output registers, cleared asynchronously by rs.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      units_q <= '0;
      tens_q  <= '0;
      pcnt_q  <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      pcnt_q  <= pcnt_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  assign bus.led1 = units_q;
  assign bus.led2 = tens_q;
  assign bus.tc   = tc_q;
  assign bus.err  = err_q;

endmodule
